// File: rtl/delta_spike_ctrl.sv
// delta_spike_ctrl: delta-modulation sequencer with threshold compare, refractory period and spike event FIFO
module delta_spike_ctrl #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int REFRAC_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   cfg_threshold,
    input  logic                cfg_off_en,
    input  logic [REFRAC_W-1:0] cfg_refrac,
    output logic                m_valid,
    output logic [1:0]          m_spike,
    input  logic                m_ready,
    output logic                busy,
    output logic [7:0]          spike_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {INIT, RUN, REFRAC} state_t;
    state_t state;
    logic [DATA_W-1:0] ref_val;
    logic [REFRAC_W-1:0] cnt;
    logic [1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic accept, push, pop, on_hit, off_hit;
    logic signed [DATA_W:0] diff, thr_s;
    assign s_ready = count != FULL_CNT;
    assign accept  = s_valid & s_ready;
    assign m_valid = count != '0;
    assign pop     = m_valid & m_ready;
    assign m_spike = m_valid ? mem[rd_ptr] : 2'b00;
    assign busy    = state != INIT;
    assign diff    = $signed({1'b0, s_data}) - $signed({1'b0, ref_val});
    assign thr_s   = $signed({1'b0, cfg_threshold});
    assign on_hit  = diff > thr_s;
    assign off_hit = cfg_off_en && (diff < -thr_s);
    assign push    = accept && state == RUN && (on_hit || off_hit);
    // Sequencer: primes the reference, compares in RUN, skips samples while refractory
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            ref_val     <= '0;
            cnt         <= '0;
            spike_count <= '0;
        end else if (accept) begin
            case (state)
                INIT: begin
                    ref_val <= s_data;
                    state   <= RUN;
                end
                RUN: if (push) begin
                    ref_val     <= s_data;
                    spike_count <= spike_count == 8'hFF ? spike_count : spike_count + 8'd1;
                    cnt         <= cfg_refrac;
                    state       <= cfg_refrac != '0 ? REFRAC : RUN;
                end
                default: begin
                    cnt   <= cnt - REFRAC_W'(1);
                    state <= cnt == REFRAC_W'(1) ? RUN : REFRAC;
                end
            endcase
        end
    end
    // Event FIFO: push never coincides with full because accept is gated by s_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= on_hit ? 2'b01 : 2'b11;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule
